mem_transfer_sequencer: RTL and testbench

//  Moore FSM that sequences the ALU-system datapath for multi-byte transfers over the byte-wide Memory.
//  - FETCH: two bytes at PC into IR.
//  - LOAD: four bytes at AR through DR into RF register Rn.
//  - STORE: RF register Rn written byte-by-byte to memory at AR.

---
 rtl/mem_xfer_pkg.sv | 33 +++
 rtl/mem_transfer_sequencer.sv | 156 +++++++++++++++
 tb/tb_mem_transfer_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_xfer_pkg.sv
// Shared state encoding and datapath control codes for the memory transfer sequencer.
// Datapath codes mirror the ALU-system control-input encodings.
package mem_xfer_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_XFER = 3'd1,
    S_WB   = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_FETCH = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_ILL   = 2'b11
  } op_t;

  localparam logic [1:0] ARF_FUN_INC  = 2'b01;
  localparam logic [1:0] ARF_OUTD_PC  = 2'b00;
  localparam logic [1:0] ARF_OUTD_AR  = 2'b10;
  localparam logic [1:0] ARF_OUTD_SP  = 2'b11;
  localparam logic [2:0] ARF_SEL_PC   = 3'b100;
  localparam logic [2:0] ARF_SEL_AR   = 3'b010;
  localparam logic [2:0] ARF_SEL_SP   = 3'b001;

  localparam logic [1:0] DR_SHR_LOADMSB = 2'b10;
  localparam logic [2:0] RF_LOAD        = 3'b010;
  localparam logic [1:0] MUXA_DR        = 2'b10;
  localparam logic [4:0] ALU_PASSA32    = 5'b10000;

endpackage

// File: rtl/mem_transfer_sequencer.sv
// Moore FSM sequencing byte-wide memory transfers: FETCH into IR, LOAD into RF via DR, STORE from RF.
// Outputs decode only registered state, so reset drives idle values without a clock.
module mem_transfer_sequencer
  import mem_xfer_pkg::*;
#(
  parameter int FETCH_BYTES = 2,
  parameter int WORD_BYTES  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [1:0] i_op,
  input  logic [1:0] i_reg,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error,
  output logic       o_mem_cs,
  output logic       o_mem_wr,
  output logic       o_ir_write,
  output logic       o_ir_lh,
  output logic       o_dr_e,
  output logic [1:0] o_dr_funsel,
  output logic [1:0] o_arf_outdsel,
  output logic [2:0] o_arf_regsel,
  output logic [1:0] o_arf_funsel,
  output logic [2:0] o_rf_outasel,
  output logic [3:0] o_rf_regsel,
  output logic [2:0] o_rf_funsel,
  output logic [3:0] o_rf_scrsel,
  output logic [1:0] o_muxasel,
  output logic [1:0] o_muxcsel,
  output logic       o_muxdsel,
  output logic [4:0] o_alu_funsel,
  output logic       o_alu_wf
);

  localparam logic [1:0] LP_FETCH_LAST = 2'(FETCH_BYTES - 1);
  localparam logic [1:0] LP_WORD_LAST  = 2'(WORD_BYTES - 1);

  state_t     r_state, w_state_nxt;
  op_t        r_op, w_op_nxt;
  logic [1:0] r_reg, w_reg_nxt;
  logic [1:0] r_k, w_k_nxt;
  logic       w_last;

  assign w_last = (r_op == OP_FETCH) ? (r_k == LP_FETCH_LAST) : (r_k == LP_WORD_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_op    <= OP_FETCH;
      r_reg   <= 2'd0;
      r_k     <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_reg   <= w_reg_nxt;
      r_k     <= w_k_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_reg_nxt   = r_reg;
    w_k_nxt     = r_k;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_state_nxt = S_IDLE;
        if (i_start) begin
          w_op_nxt    = op_t'(i_op);
          w_reg_nxt   = i_reg;
          w_k_nxt     = 2'd0;
          w_state_nxt = (op_t'(i_op) == OP_ILL) ? S_ERR : S_XFER;
        end
      end
      S_XFER: begin
        // k returns to 0 when the transfer leaves XFER, never mid-transfer
        if (w_last) begin
          w_k_nxt     = 2'd0;
          w_state_nxt = (r_op == OP_LOAD) ? S_WB : S_DONE;
        end else begin
          w_k_nxt = r_k + 2'd1;
        end
      end
      S_WB:    w_state_nxt = S_DONE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy        = 1'b1;
    o_done        = 1'b0;
    o_error       = 1'b0;
    o_mem_cs      = 1'b1;
    o_mem_wr      = 1'b0;
    o_ir_write    = 1'b0;
    o_ir_lh       = 1'b0;
    o_dr_e        = 1'b0;
    o_dr_funsel   = 2'b00;
    o_arf_outdsel = 2'b00;
    o_arf_regsel  = 3'b000;
    o_arf_funsel  = 2'b00;
    o_rf_outasel  = 3'b000;
    o_rf_regsel   = 4'b0000;
    o_rf_funsel   = 3'b000;
    o_rf_scrsel   = 4'b0000;
    o_muxasel     = 2'b00;
    o_muxcsel     = 2'b00;
    o_muxdsel     = 1'b0;
    o_alu_funsel  = 5'b00000;
    o_alu_wf      = 1'b0;
    case (r_state)
      S_IDLE: o_busy = 1'b0;
      S_DONE: begin
        o_busy = 1'b0;
        o_done = 1'b1;
      end
      S_ERR: o_error = 1'b1;
      S_XFER: begin
        o_mem_cs     = 1'b0;
        o_arf_funsel = ARF_FUN_INC;
        case (r_op)
          OP_FETCH: begin
            o_arf_outdsel = ARF_OUTD_PC;
            o_arf_regsel  = ARF_SEL_PC;
            o_ir_write    = 1'b1;
            o_ir_lh       = r_k[0];
          end
          OP_LOAD: begin
            o_arf_outdsel = ARF_OUTD_AR;
            o_arf_regsel  = ARF_SEL_AR;
            o_dr_e        = 1'b1;
            o_dr_funsel   = DR_SHR_LOADMSB;
          end
          default: begin
            o_mem_wr      = 1'b1;
            o_arf_outdsel = ARF_OUTD_AR;
            o_arf_regsel  = ARF_SEL_AR;
            o_rf_outasel  = {1'b0, r_reg};
            o_alu_funsel  = ALU_PASSA32;
            o_muxcsel     = r_k;
          end
        endcase
      end
      S_WB: begin
        o_muxasel   = MUXA_DR;
        o_rf_funsel = RF_LOAD;
        o_rf_regsel = 4'b0001 << r_reg;
      end
      default: o_busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_transfer_sequencer.sv
// Directed bench: a small behavioural datapath (memory, PC/AR, IR, DR, RF) follows the sequencer outputs.
module tb_mem_transfer_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] op_in;
  logic [1:0] reg_in;
  logic       busy, done, error, mem_cs, mem_wr, ir_write, ir_lh, dr_e, muxdsel, alu_wf;
  logic [1:0] dr_funsel, arf_outdsel, arf_funsel, muxasel, muxcsel;
  logic [2:0] arf_regsel, rf_outasel, rf_funsel;
  logic [3:0] rf_regsel, rf_scrsel;
  logic [4:0] alu_funsel;

  always #5 clk = ~clk;

  mem_transfer_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op_in), .i_reg(reg_in),
    .o_busy(busy), .o_done(done), .o_error(error), .o_mem_cs(mem_cs), .o_mem_wr(mem_wr),
    .o_ir_write(ir_write), .o_ir_lh(ir_lh), .o_dr_e(dr_e), .o_dr_funsel(dr_funsel),
    .o_arf_outdsel(arf_outdsel), .o_arf_regsel(arf_regsel), .o_arf_funsel(arf_funsel),
    .o_rf_outasel(rf_outasel), .o_rf_regsel(rf_regsel), .o_rf_funsel(rf_funsel),
    .o_rf_scrsel(rf_scrsel), .o_muxasel(muxasel), .o_muxcsel(muxcsel), .o_muxdsel(muxdsel),
    .o_alu_funsel(alu_funsel), .o_alu_wf(alu_wf)
  );

  // Behavioural datapath, including a preload port the stimulus uses while the sequencer is idle
  logic [7:0]  mem [0:255];
  logic [15:0] pc, ar, ir;
  logic [31:0] dr;
  logic [31:0] rf [0:3];
  logic        ld_en, ld_mem_en;
  logic [15:0] ld_pc, ld_ar;
  logic [31:0] ld_r1;
  logic [7:0]  ld_mem_addr, ld_mem_dat;
  logic [15:0] addr;
  logic [7:0]  rdat, wdat;
  logic [31:0] alu_a;

  assign addr  = (arf_outdsel == 2'b10) ? ar : pc;
  assign rdat  = mem[addr[7:0]];
  assign alu_a = (muxdsel == 1'b0 && alu_funsel == 5'b10000) ? rf[rf_outasel[1:0]] : 32'h0;
  assign wdat  = alu_a[8*muxcsel +: 8];

  always @(posedge clk) begin
    if (ld_mem_en) mem[ld_mem_addr] <= ld_mem_dat;
    else if (!mem_cs && mem_wr) mem[addr[7:0]] <= wdat;
    if (!mem_cs && !mem_wr && ir_write) begin
      if (ir_lh) ir[15:8] <= rdat;
      else       ir[7:0]  <= rdat;
    end
    if (dr_e && dr_funsel == 2'b10) dr <= {rdat, dr[31:8]};
    if (ld_en) begin
      pc <= ld_pc;
      ar <= ld_ar;
      rf[0] <= ld_r1;
      rf[1] <= 32'h0;
      rf[2] <= 32'h0;
      rf[3] <= 32'h0;
    end else begin
      if (arf_funsel == 2'b01 && arf_regsel[2]) pc <= pc + 16'd1;
      if (arf_funsel == 2'b01 && arf_regsel[1]) ar <= ar + 16'd1;
      if (rf_funsel == 3'b010 && muxasel == 2'b10)
        for (int i = 0; i < 4; i++) if (rf_regsel[i]) rf[i] <= dr;
    end
  end

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [15:0] p, input logic [15:0] a, input logic [31:0] r1);
    ld_pc = p; ld_ar = a; ld_r1 = r1; ld_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic mem_put(input logic [7:0] a, input logic [7:0] d);
    ld_mem_addr = a; ld_mem_dat = d; ld_mem_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ld_mem_en = 1'b0;
  endtask

  // Start is accepted on edge 0; returns the cycle (negedge after edge n) in which Done is seen.
  // With noise set, Start stays high with a different Op/Reg while the transfer is busy.
  task automatic run_op(input logic [1:0] op, input logic [1:0] rg, input bit noise, output int cyc);
    cyc = -1;
    start = 1'b1; op_in = op; reg_in = rg;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done) begin
        cyc = c;
        break;
      end
      start  = noise;
      op_in  = noise ? 2'b10 : op;
      reg_in = noise ? 2'd3 : rg;
    end
    start = 1'b0;
  endtask

  int cyc;
  int seen;

  initial begin
    rst_n = 1'b0; start = 1'b0; op_in = 2'b00; reg_in = 2'd0;
    ld_en = 1'b0; ld_mem_en = 1'b0; ld_pc = 16'h0; ld_ar = 16'h0; ld_r1 = 32'h0;
    ld_mem_addr = 8'h0; ld_mem_dat = 8'h0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_error", {31'b0, error}, 32'd0);
    chk("rst_mem_cs", {31'b0, mem_cs}, 32'd1);
    chk("rst_enables", {19'b0, ir_write, dr_e, arf_regsel, rf_regsel, rf_scrsel, alu_wf}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    preload(16'h0010, 16'h0020, 32'hDEADBEEF);
    mem_put(8'h10, 8'h34); mem_put(8'h11, 8'h12);
    mem_put(8'h20, 8'h78); mem_put(8'h21, 8'h56); mem_put(8'h22, 8'h34); mem_put(8'h23, 8'h12);

    run_op(2'b00, 2'd0, 1'b0, cyc);
    chk("fetch_done_cycle", cyc, 32'd3);
    @(negedge clk);
    chk("fetch_done_pulse", {31'b0, done}, 32'd0);
    chk("fetch_ir", {16'h0, ir}, 32'h1234);
    chk("fetch_pc", {16'h0, pc}, 32'h0012);

    run_op(2'b01, 2'd1, 1'b1, cyc);
    chk("load_done_cycle", cyc, 32'd6);
    @(negedge clk);
    chk("load_r2", rf[1], 32'h12345678);
    chk("load_ar", {16'h0, ar}, 32'h0024);
    chk("load_r1_kept", rf[0], 32'hDEADBEEF);
    chk("load_r4_untouched", rf[3], 32'h0);

    preload(16'h0012, 16'h0040, 32'hDEADBEEF);
    run_op(2'b10, 2'd0, 1'b0, cyc);
    chk("store_done_cycle", cyc, 32'd5);
    @(negedge clk);
    chk("store_mem", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'hDEADBEEF);
    chk("store_b0", {24'h0, mem[8'h40]}, 32'h0000_00EF);
    chk("store_ar", {16'h0, ar}, 32'h0044);

    start = 1'b1; op_in = 2'b11; reg_in = 2'd2;
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", {31'b0, error}, 32'd1);
    chk("err_busy", {31'b0, busy}, 32'd1);
    chk("err_quiet", {27'b0, mem_cs, ir_write, dr_e, |rf_regsel, |arf_regsel}, 32'h10);
    @(negedge clk);
    chk("err_one_cycle", {31'b0, error}, 32'd0);
    chk("err_idle", {30'b0, busy, done}, 32'd0);

    preload(16'h0012, 16'h0020, 32'hDEADBEEF);
    start = 1'b1; op_in = 2'b01; reg_in = 2'd1;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("midrst_active", {30'b0, mem_cs, dr_e}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_async", {28'b0, busy, mem_cs, dr_e, |arf_regsel}, 32'h4);
    repeat (2) @(negedge clk);
    chk("midrst_ar", {16'h0, ar}, 32'h0022);
    chk("midrst_no_wb", rf[1], 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    preload(16'h0020, 16'h0050, 32'hCAFEF00D);
    run_op(2'b10, 2'd0, 1'b0, cyc);
    chk("b2b_store_done", cyc, 32'd5);
    start = 1'b1; op_in = 2'b00; reg_in = 2'd0;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_no_idle", {30'b0, busy, ir_write}, 32'd3);
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk);
      if (done) seen = c + 2;
    end
    chk("b2b_fetch_done_cycle", seen, 32'd3);
    chk("b2b_ir", {16'h0, ir}, 32'h5678);
    chk("b2b_store_mem", {mem[8'h53], mem[8'h52], mem[8'h51], mem[8'h50]}, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
